// File: rtl/axi_stream_remove_header.sv
// Strips byte_remove_cnt leading bytes from each AXI-Stream packet and re-aligns the rest to the MSB.
// Latency: 1 cycle when nothing is stripped, otherwise 1 cycle after the 2nd (or last) beat; output stalls hold state.
module axi_stream_remove_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_remove,
  input  logic [BYTE_CNT_WD-1:0]  byte_remove_cnt,
  output logic                    ready_remove,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out
);

  localparam int NW = BYTE_CNT_WD + 1;

  typedef enum logic [1:0] {IDLE, FIRST, STREAM, TAIL} state_t;

  function automatic logic [DATA_BYTE_WD-1:0] keep_top(input logic [NW-1:0] k);
    keep_top = ~({DATA_BYTE_WD{1'b1}} >> k);
  endfunction

  function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] k);
    byte_mask = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) byte_mask[i*8 +: 8] = {8{k[i]}};
  endfunction

  function automatic logic [NW-1:0] popcnt(input logic [DATA_BYTE_WD-1:0] k);
    popcnt = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) if (k[i]) popcnt = popcnt + 1'b1;
  endfunction

  state_t                  state_q, state_d;
  logic [BYTE_CNT_WD-1:0]  cnt_q, cnt_d;
  logic [DATA_WD-1:0]      res_q, res_d;
  logic [NW-1:0]           tail_q, tail_d;
  logic                    valid_q, last_q;
  logic [DATA_WD-1:0]      data_q;
  logic [DATA_BYTE_WD-1:0] keep_q;

  logic                    ofree, rdy_in_c, acc;
  logic                    emit, e_last;
  logic [DATA_WD-1:0]      e_raw, e_dat, hi_in, lo_in;
  logic [DATA_BYTE_WD-1:0] e_keep;
  logic [NW-1:0]           n_in, cnt_ext;
  int unsigned             c_bits;

  assign ofree        = !valid_q || ready_out;
  assign rdy_in_c     = ((state_q == FIRST) || (state_q == STREAM)) && ofree;
  assign acc          = valid_in && rdy_in_c;
  assign ready_in     = rdy_in_c;
  // Gated with rst_n so the command port reads not-ready while reset is held.
  assign ready_remove = (state_q == IDLE) && rst_n;

  always_comb begin
    c_bits  = 32'({cnt_q, 3'b000});
    cnt_ext = {1'b0, cnt_q};
    hi_in   = (c_bits == 0) ? '0 : (data_in >> (DATA_WD - c_bits));
    lo_in   = data_in << c_bits;
    n_in    = last_in ? popcnt(keep_in) : NW'(DATA_BYTE_WD);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    tail_d  = tail_q;
    emit    = 1'b0;
    e_raw   = '0;
    e_keep  = '0;
    e_last  = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_remove) begin
          cnt_d   = byte_remove_cnt;
          state_d = FIRST;
        end
      end
      FIRST, STREAM: begin
        if (acc) begin
          if (cnt_q == '0) begin
            emit    = 1'b1;
            e_raw   = data_in;
            e_keep  = keep_top(n_in);
            e_last  = last_in;
            state_d = last_in ? IDLE : STREAM;
          end else if (state_q == FIRST) begin
            res_d   = lo_in;
            state_d = STREAM;
            if (last_in) begin
              // A one-beat packet either vanishes entirely or yields its surviving bytes now.
              state_d = IDLE;
              if (n_in > cnt_ext) begin
                emit   = 1'b1;
                e_raw  = lo_in;
                e_keep = keep_top(n_in - cnt_ext);
                e_last = 1'b1;
              end
            end
          end else begin
            res_d  = lo_in;
            emit   = 1'b1;
            e_raw  = res_q | hi_in;
            e_keep = '1;
            if (last_in) begin
              if (n_in <= cnt_ext) begin
                e_keep  = keep_top(NW'(DATA_BYTE_WD) - cnt_ext + n_in);
                e_last  = 1'b1;
                state_d = IDLE;
              end else begin
                tail_d  = n_in - cnt_ext;
                state_d = TAIL;
              end
            end
          end
        end
      end
      TAIL: begin
        if (ofree) begin
          emit    = 1'b1;
          e_raw   = res_q;
          e_keep  = keep_top(tail_q);
          e_last  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    e_dat = e_raw & byte_mask(e_keep);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      tail_q  <= tail_d;
      if (ofree) begin
        valid_q <= emit;
        data_q  <= e_dat;
        keep_q  <= e_keep;
        last_q  <= e_last;
      end
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign keep_out  = keep_q;
  assign last_out  = last_q;

endmodule

// File: tb/tb_axi_stream_remove_header.sv
// Bench for axi_stream_remove_header: table vectors, hand-written corner sequences and random packets,
// all checked through an expected-beat queue against a byte-level reference model.
module tb_axi_stream_remove_header;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_remove, ready_remove;
  logic [1:0]  byte_remove_cnt;
  logic        valid_in, ready_in, last_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        valid_out, last_out, ready_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;

  always #5 clk = ~clk;

  axi_stream_remove_header #(.DATA_WD(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_remove(valid_remove), .byte_remove_cnt(byte_remove_cnt), .ready_remove(ready_remove),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .ready_out(ready_out)
  );

  typedef struct packed {logic [31:0] d; logic [3:0] k; logic l;} beat_t;
  typedef struct {
    int          cnt;
    int          nb;
    logic [31:0] d [6];
    logic [3:0]  lk;
    int          rmode;
    int          ne;
    logic [31:0] ed [7];
    logic [3:0]  ek [7];
  } vec_t;

  beat_t       expq[$];
  vec_t        vt[6];
  int          checks = 0;
  int          errors = 0;
  int          rmode  = 0;
  int          pkt_cnt, pkt_nb;
  logic [31:0] pkt_d [6];
  logic [3:0]  pkt_lk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: flatten the packet to bytes, drop the header, repack MSB-first.
  task automatic model_push();
    logic [7:0]  bq[$];
    logic [31:0] d;
    logic [3:0]  k;
    int          n;
    for (int b = 0; b < pkt_nb; b++) begin
      n = (b == pkt_nb - 1) ? $countones(pkt_lk) : 4;
      for (int j = 0; j < n; j++) bq.push_back(pkt_d[b][31-8*j -: 8]);
    end
    for (int j = 0; j < pkt_cnt; j++) if (bq.size() > 0) void'(bq.pop_front());
    while (bq.size() > 0) begin
      d = '0;
      k = '0;
      for (int j = 0; j < 4; j++) begin
        if (bq.size() > 0) begin
          d[31-8*j -: 8] = bq.pop_front();
          k[3-j] = 1'b1;
        end
      end
      expq.push_back('{d: d, k: k, l: (bq.size() == 0)});
    end
  endtask

  task automatic send_cmd(input int c);
    int t = 0;
    bit hs;
    byte_remove_cnt = 2'(c);
    valid_remove = 1'b1;
    do begin
      @(negedge clk); hs = valid_remove && ready_remove;
      @(posedge clk); #1; t++;
    end while (!hs && t < 200);
    valid_remove = 1'b0;
    chk("cmd_handshake", 64'(hs), 64'd1);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int t = 0;
    bit hs;
    data_in = d; keep_in = k; last_in = l; valid_in = 1'b1;
    do begin
      @(negedge clk); hs = valid_in && ready_in;
      @(posedge clk); #1; t++;
    end while (!hs && t < 200);
    valid_in = 1'b0; last_in = 1'b0;
    chk("beat_handshake", 64'(hs), 64'd1);
  endtask

  task automatic send_pkt();
    send_cmd(pkt_cnt);
    for (int b = 0; b < pkt_nb; b++)
      send_beat(pkt_d[b], (b == pkt_nb - 1) ? pkt_lk : 4'hF, b == pkt_nb - 1);
  endtask

  task automatic drain();
    int t = 0;
    while ((expq.size() != 0 || valid_out) && t < 200) begin
      @(posedge clk); #1; t++;
    end
    chk("drain_pending", 64'(expq.size()), 64'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       ready_out = 1'b1;
        1:       ready_out = ~ready_out;
        default: ready_out = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    bit    stall_prev = 1'b0;
    beat_t held, e;
    logic  held_v;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (stall_prev) begin
          chk("hold_valid", 64'(valid_out), 64'(held_v));
          chk("hold_beat", 64'({data_out, keep_out, last_out}), 64'(held));
        end
        if (valid_out && ready_out) begin
          if (expq.size() == 0) begin
            chk("unexpected_beat", 64'({data_out, keep_out, last_out}), 64'd0);
          end else begin
            e = expq.pop_front();
            chk("out_data", 64'(data_out), 64'(e.d));
            chk("out_keep", 64'(keep_out), 64'(e.k));
            chk("out_last", 64'(last_out), 64'(e.l));
          end
        end
        stall_prev = valid_out && !ready_out;
        held_v = valid_out;
        held = '{d: data_out, k: keep_out, l: last_out};
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial begin
    logic [3:0] ones = 4'hF;
    vt[0] = '{cnt: 1, nb: 2, d: '{32'hAABBCCDD, 32'h11223344, 0, 0, 0, 0}, lk: 4'hF, rmode: 0,
              ne: 2, ed: '{32'hBBCCDD11, 32'h22334400, 0, 0, 0, 0, 0}, ek: '{4'hF, 4'hE, 0, 0, 0, 0, 0}};
    vt[1] = '{cnt: 2, nb: 2, d: '{32'hAABBCCDD, 32'h55660000, 0, 0, 0, 0}, lk: 4'hC, rmode: 0,
              ne: 1, ed: '{32'hCCDD5566, 0, 0, 0, 0, 0, 0}, ek: '{4'hF, 0, 0, 0, 0, 0, 0}};
    vt[2] = '{cnt: 3, nb: 1, d: '{32'h12345678, 0, 0, 0, 0, 0}, lk: 4'hE, rmode: 0,
              ne: 0, ed: '{0, 0, 0, 0, 0, 0, 0}, ek: '{0, 0, 0, 0, 0, 0, 0}};
    vt[3] = '{cnt: 0, nb: 6, d: '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555,
              32'h6677AABB}, lk: 4'h8, rmode: 0, ne: 6,
              ed: '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555, 32'h66000000, 0},
              ek: '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h8, 0}};
    vt[4] = '{cnt: 1, nb: 4, d: '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 0, 0}, lk: 4'hF,
              rmode: 1, ne: 4, ed: '{32'h02030405, 32'h06070809, 32'h0A0B0C0D, 32'h0E0F1000, 0, 0, 0},
              ek: '{4'hF, 4'hF, 4'hF, 4'hE, 0, 0, 0}};
    vt[5] = vt[4];
    vt[5].rmode = 0;

    rst_n = 1'b0; valid_remove = 1'b0; byte_remove_cnt = '0; valid_in = 1'b0;
    data_in = '0; keep_in = '0; last_in = 1'b0; ready_out = 1'b1;
    #12;
    chk("rst_valid_out", 64'(valid_out), 64'd0);
    chk("rst_last_out", 64'(last_out), 64'd0);
    chk("rst_ready_in", 64'(ready_in), 64'd0);
    chk("rst_ready_remove", 64'(ready_remove), 64'd0);
    chk("rst_data_keep", 64'({data_out, keep_out}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready_remove", 64'(ready_remove), 64'd1);

    for (int v = 0; v < 6; v++) begin
      rmode = vt[v].rmode;
      for (int i = 0; i < vt[v].ne; i++)
        expq.push_back('{d: vt[v].ed[i], k: vt[v].ek[i], l: (i == vt[v].ne - 1)});
      pkt_cnt = vt[v].cnt; pkt_nb = vt[v].nb; pkt_d = vt[v].d; pkt_lk = vt[v].lk;
      send_pkt();
      drain();
      if (vt[v].ne == 0) chk("stripped_no_output", 64'(valid_out), 64'd0);
    end

    // Zero strip: registered pass-through, output visible right after the accepting edge.
    rmode = 0;
    send_cmd(0);
    expq.push_back('{d: 32'hCAFEF00D, k: 4'hF, l: 1'b1});
    send_beat(32'hCAFEF00D, 4'hF, 1'b1);
    chk("c0_latency_valid", 64'(valid_out), 64'd1);
    chk("c0_latency_data", 64'(data_out), 64'hCAFEF00D);
    drain();

    // Nonzero strip: nothing after beat 0, first output right after beat 1.
    pkt_cnt = 1; pkt_nb = 2; pkt_d[0] = 32'hDEADBEEF; pkt_d[1] = 32'h0BADF00D; pkt_lk = 4'hC;
    model_push();
    send_cmd(1);
    send_beat(pkt_d[0], 4'hF, 1'b0);
    chk("c1_lat_beat0", 64'(valid_out), 64'd0);
    send_beat(pkt_d[1], pkt_lk, 1'b1);
    chk("c1_lat_beat1", 64'(valid_out), 64'd1);
    drain();

    // Reset asserted while the third beat of a C=2 packet is offered.
    pkt_cnt = 2; pkt_nb = 4;
    pkt_d[0] = 32'h10203040; pkt_d[1] = 32'h50607080; pkt_d[2] = 32'h90A0B0C0; pkt_d[3] = 32'hD0E0F000;
    pkt_lk = 4'hF;
    model_push();
    send_cmd(2);
    send_beat(pkt_d[0], 4'hF, 1'b0);
    send_beat(pkt_d[1], 4'hF, 1'b0);
    data_in = pkt_d[2]; keep_in = 4'hF; valid_in = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid_out", 64'(valid_out), 64'd0);
    chk("midrst_ready_in", 64'(ready_in), 64'd0);
    chk("midrst_keep_last", 64'({keep_out, last_out}), 64'd0);
    expq.delete();
    valid_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    pkt_d[0] = 32'hA1A2A3A4; pkt_d[1] = 32'hB1B2B3B4; pkt_d[2] = 32'hC1C2C3C4; pkt_lk = 4'hE; pkt_nb = 3;
    model_push();
    send_pkt();
    drain();

    rmode = 2;
    for (int p = 0; p < 40; p++) begin
      pkt_cnt = $urandom_range(0, 3);
      pkt_nb  = $urandom_range(1, 5);
      for (int b = 0; b < 6; b++) pkt_d[b] = $urandom;
      pkt_lk = ~(ones >> $urandom_range(1, 4));
      model_push();
      send_pkt();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
